decoder_seq: RTL and testbench
==============================

Name: decoder_seq

Overview:
- Parametrised, registered successor to the team's 3-to-8 line decoder.
- Decodes an SEL_W-bit index onto 2**SEL_W active-low strobes, gated by the classic G1/G2A_n/G2B_n enable triple.
- Adds a break-before-make gap between channels, plus an autonomous scan mode that cycles channels with programmable dwell.
- Used as chip-select generator / display-digit multiplexer.

Parameters:
- SEL_W, 3, select width; output count OUT_N = 2**SEL_W.
- DWELL_W, 8, width of dwell_i and the dwell counter.
- GAP_CYC, 1, blank cycles inserted between channels (0 = no gap); counter width $clog2(GAP_CYC+1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- g1_en_i  in  1  enable, active-high.
- g2a_en_n_i  in  1  enable, active-low.
- g2b_en_n_i  in  1  enable, active-low.
- mode_i  in  1  0 = direct (select_i), 1 = scan.
- select_i  in  SEL_W  channel index, direct mode.
- dwell_i  in  DWELL_W  scan: each channel is driven dwell_i+1 cycles.
- last_i  in  SEL_W  scan: highest channel visited, then wrap to 0.
- yn_o  out  OUT_N  strobes, active-low, at most one bit low.
- active_o  out  1  high when any yn_o bit is low.
- idx_o  out  SEL_W  index currently driven (0 when none).
- wrap_o  out  1  one-cycle pulse when scan wraps last_i -> 0.

Behaviour:
- en = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i, sampled each edge.
- Outputs are decoded only from registers:
  - yn_o = ~(1 << idx_q) in DRIVE, all ones otherwise.
  - active_o = (state == DRIVE).
  - idx_o = idx_q in DRIVE, else 0.
- Reset: state IDLE, idx_q = 0, mode_q = 0, counters 0. yn_o = all ones, active_o = 0, idx_o = 0, wrap_o = 0.
- Reset has priority over every event, including mid-DRIVE/GAP. Next cycle the outputs are all inactive.
- FSM states: IDLE, DRIVE, GAP.
- IDLE:
  - If en: mode_q <= mode_i and go to DRIVE.
  - idx_q <= select_i (direct) or 0 (scan).
  - dwell_cnt <= dwell_i.
  - Latency from en to yn_o active is 1 cycle.
- Any state, !en or mode_i != mode_q: go to IDLE next edge. Outputs go inactive 1 cycle later; no gap is counted.
- DRIVE, direct mode:
  - If select_i == idx_q, hold.
  - Otherwise, if GAP_CYC > 0, go to GAP with gap_cnt <= GAP_CYC-1; else idx_q <= select_i and stay in DRIVE.
- DRIVE, scan mode:
  - If dwell_cnt != 0, decrement.
  - Else nxt = (idx_q >= last_i) ? 0 : idx_q+1, and dwell_cnt <= dwell_i.
  - If GAP_CYC > 0, go to GAP and hold nxt in idx_q's pending register; else idx_q <= nxt.
  - wrap_o = 1 in the cycle following the last drive cycle of a channel where idx_q >= last_i.
- GAP:
  - yn_o all ones.
  - Decrement gap_cnt; at 0 go to DRIVE.
  - idx_q <= select_i sampled at GAP exit (direct) or the pending nxt (scan).
  - In scan mode, dwell_cnt is reloaded from dwell_i at GAP exit.
- Boundaries:
  - last_i = 0 in scan: channel 0 only, wrap_o pulses every channel period.
  - last_i lowered below idx_q mid-scan: wraps to 0 at the end of the current dwell.
  - dwell_i = 0: a 1-cycle drive.
  - Direct-mode select_i returning to idx_q during GAP: the gap still completes.
  - Channel period in scan = dwell_i+1+GAP_CYC cycles.
- Invariants:
  - Never two yn_o bits low.
  - With GAP_CYC > 0, never a low-to-low transition between different bits on adjacent cycles.

Decomposition:
- Package decoder_seq_pkg holds:
  - state_t enum {IDLE, DRIVE, GAP}.
  - Mode constants MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1.
  - Function onehot_n(idx) returning the active-low decode, parametrised by SEL_W.
- No sub-module: FSM, dwell counter and gap counter live in one module.

Test Plan:
- Reset / idle strobes: rst_i=1 for 2 cycles with en=1 -> yn_o=8'hFF, active_o=0, wrap_o=0. Release with g2a_en_n_i=1 -> yn_o stays 8'hFF.
- Direct decode and gap: GAP_CYC=1, en=1, select_i=5 -> after 1 cycle yn_o=8'hDF, idx_o=5. Change to 2 -> one cycle of 8'hFF, then 8'hFB.
- Disable mid-drive: deassert g1_en_i while yn_o=8'hDF -> yn_o=8'hFF next cycle; state IDLE. Re-enable -> active after 1 cycle.
- Scan sequence and wrap: mode_i=1, dwell_i=2, last_i=3, GAP_CYC=1 ->
  - Channels 0,1,2,3 each low for 3 cycles, separated by 1 blank.
  - 16-cycle period; wrap_o high exactly once per period, in the blank after channel 3.
- Scan edge cases:
  - last_i=0, dwell_i=0 -> yn_o alternates 8'hFE / 8'hFF; wrap_o pulses every blank.
  - Lowering last_i from 7 to 1 while idx_o=4 -> next channel driven is 0.
- Mode switch and reset mid-scan:
  - Toggle mode_i to 0 during channel 2 -> yn_o=8'hFF next cycle, then select_i decoded.
  - rst_i during GAP -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg: FSM states, mode codes and the active-low line decode shared by decoder_seq
package decoder_seq_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN = 1'b1;
    localparam int SEL_W_MAX = 8;
    // decodes at the widest supported select; callers size-cast down to their 2**SEL_W strobes
    function automatic logic [2**SEL_W_MAX-1:0] onehot_n(input logic [SEL_W_MAX-1:0] idx);
        logic [2**SEL_W_MAX-1:0] v;
        v = '1;
        v[idx] = 1'b0;
        return v;
    endfunction
endpackage

// File: rtl/decoder_seq.sv
// decoder_seq: registered enable-gated line decoder with break-before-make gap and dwell-timed scan
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL_W = 8,
    parameter int GAP_CYC = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 g1_en_i,
    input  logic                 g2a_en_n_i,
    input  logic                 g2b_en_n_i,
    input  logic                 mode_i,
    input  logic [SEL_W-1:0]     select_i,
    input  logic [DWELL_W-1:0]   dwell_i,
    input  logic [SEL_W-1:0]     last_i,
    output logic [2**SEL_W-1:0]  yn_o,
    output logic                 active_o,
    output logic [SEL_W-1:0]     idx_o,
    output logic                 wrap_o
);
    localparam int OUT_N = 2**SEL_W;
    localparam int GAP_W = GAP_CYC > 0 ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
    state_t r_state, w_state;
    logic [SEL_W-1:0] r_idx, w_idx, r_pend, w_pend, w_nxt;
    logic r_mode, w_mode, r_wrap, w_wrap, w_en;
    logic [DWELL_W-1:0] r_dwell, w_dwell;
    logic [GAP_W-1:0] r_gap, w_gap;
    assign w_en = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i;
    assign w_nxt = (r_idx >= last_i) ? '0 : r_idx + 1'b1;
    assign yn_o = (r_state == DRIVE) ? OUT_N'(onehot_n(SEL_W_MAX'(r_idx))) : '1;
    assign active_o = r_state == DRIVE;
    assign idx_o = (r_state == DRIVE) ? r_idx : '0;
    assign wrap_o = r_wrap;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_idx <= '0;
            r_pend <= '0;
            r_mode <= MODE_DIRECT;
            r_dwell <= '0;
            r_gap <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx <= w_idx;
            r_pend <= w_pend;
            r_mode <= w_mode;
            r_dwell <= w_dwell;
            r_gap <= w_gap;
            r_wrap <= w_wrap;
        end
    end
    always_comb begin
        w_state = r_state;
        w_idx = r_idx;
        w_pend = r_pend;
        w_mode = r_mode;
        w_dwell = r_dwell;
        w_gap = r_gap;
        w_wrap = 1'b0;
        if (!w_en) begin
            w_state = IDLE;
        end else if (r_state == IDLE) begin
            w_state = DRIVE;
            w_mode = mode_i;
            w_idx = (mode_i == MODE_SCAN) ? '0 : select_i;
            w_dwell = dwell_i;
        end else if (mode_i != r_mode) begin
            w_state = IDLE;
        end else if (r_state == DRIVE) begin
            if (r_mode == MODE_DIRECT) begin
                if (select_i != r_idx) begin
                    if (GAP_CYC > 0) begin
                        w_state = GAP;
                        w_gap = GAP_LOAD;
                    end else begin
                        w_idx = select_i;
                    end
                end
            end else if (r_dwell != '0) begin
                w_dwell = r_dwell - 1'b1;
            end else begin
                // end of this channel's dwell: flag the wrap and move on, via the gap if one is configured
                w_dwell = dwell_i;
                w_wrap = r_idx >= last_i;
                if (GAP_CYC > 0) begin
                    w_state = GAP;
                    w_gap = GAP_LOAD;
                    w_pend = w_nxt;
                end else begin
                    w_idx = w_nxt;
                end
            end
        end else if (r_gap != '0) begin
            w_gap = r_gap - 1'b1;
        end else begin
            w_state = DRIVE;
            w_idx = (r_mode == MODE_SCAN) ? r_pend : select_i;
            if (r_mode == MODE_SCAN) w_dwell = dwell_i;
        end
    end
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: scoreboarded directed checks of decoder_seq at SEL_W=3, GAP_CYC=1
module tb_decoder_seq;
    logic clk_i, rst_i, g1_en_i, g2a_en_n_i, g2b_en_n_i, mode_i, active_o, wrap_o;
    logic [2:0] select_i, last_i, idx_o;
    logic [7:0] dwell_i, yn_o;
    typedef struct {
        logic [7:0] yn;
        logic [2:0] idx;
        logic wrap;
    } exp_t;
    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    decoder_seq #(.SEL_W(3), .DWELL_W(8), .GAP_CYC(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .g1_en_i(g1_en_i), .g2a_en_n_i(g2a_en_n_i),
        .g2b_en_n_i(g2b_en_n_i), .mode_i(mode_i), .select_i(select_i), .dwell_i(dwell_i),
        .last_i(last_i), .yn_o(yn_o), .active_o(active_o), .idx_o(idx_o), .wrap_o(wrap_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dn(input int ch);
        logic [7:0] v;
        v = 8'hFF;
        v[ch] = 1'b0;
        return v;
    endfunction

    task automatic apply(input string tag, input logic [7:0] yn, input logic [2:0] idx, input logic wrap);
        exp_t e;
        q.push_back('{yn, idx, wrap});
        @(posedge clk_i);
        #1;
        e = q.pop_front();
        chk({tag, ".yn"}, 32'(yn_o), 32'(e.yn));
        chk({tag, ".act"}, 32'(active_o), 32'(e.yn != 8'hFF));
        chk({tag, ".idx"}, 32'(idx_o), 32'(e.idx));
        chk({tag, ".wrap"}, 32'(wrap_o), 32'(e.wrap));
    endtask

    initial begin
        int p, ch;
        rst_i = 1'b1; g1_en_i = 1'b1; g2a_en_n_i = 1'b0; g2b_en_n_i = 1'b0;
        mode_i = 1'b0; select_i = 3'd0; dwell_i = 8'd0; last_i = 3'd0;
        apply("rst0", 8'hFF, 3'd0, 1'b0);
        apply("rst1", 8'hFF, 3'd0, 1'b0);
        rst_i = 1'b0; g2a_en_n_i = 1'b1;
        apply("dis0", 8'hFF, 3'd0, 1'b0);
        apply("dis1", 8'hFF, 3'd0, 1'b0);
        g2a_en_n_i = 1'b0; select_i = 3'd5;
        apply("d5", 8'hDF, 3'd5, 1'b0);
        apply("d5h", 8'hDF, 3'd5, 1'b0);
        select_i = 3'd2;
        apply("gap52", 8'hFF, 3'd0, 1'b0);
        apply("d2", 8'hFB, 3'd2, 1'b0);
        select_i = 3'd5;
        apply("gap25", 8'hFF, 3'd0, 1'b0);
        apply("d5b", 8'hDF, 3'd5, 1'b0);
        g1_en_i = 1'b0;
        apply("off", 8'hFF, 3'd0, 1'b0);
        g1_en_i = 1'b1;
        apply("on", 8'hDF, 3'd5, 1'b0);
        select_i = 3'd2;
        apply("gapret", 8'hFF, 3'd0, 1'b0);
        select_i = 3'd5;
        apply("ret5", 8'hDF, 3'd5, 1'b0);
        g2b_en_n_i = 1'b1;
        apply("g2b", 8'hFF, 3'd0, 1'b0);
        g2b_en_n_i = 1'b0;
        apply("g2bon", 8'hDF, 3'd5, 1'b0);
        mode_i = 1'b1; dwell_i = 8'd2; last_i = 3'd3;
        apply("tosc", 8'hFF, 3'd0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            p = k % 16;
            ch = p / 4;
            if (p % 4 != 3) apply("scan", dn(ch), 3'(ch), 1'b0);
            else apply("scanb", 8'hFF, 3'd0, ch == 3);
        end
        last_i = 3'd0; dwell_i = 8'd0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) apply("l0d", 8'hFE, 3'd0, 1'b0);
            else apply("l0b", 8'hFF, 3'd0, 1'b1);
        end
        last_i = 3'd7; dwell_i = 8'd1;
        for (int c = 0; c < 4; c++) begin
            apply("up", dn(c), 3'(c), 1'b0);
            apply("up", dn(c), 3'(c), 1'b0);
            apply("upb", 8'hFF, 3'd0, 1'b0);
        end
        apply("c4a", 8'hEF, 3'd4, 1'b0);
        last_i = 3'd1;
        apply("c4b", 8'hEF, 3'd4, 1'b0);
        apply("lowwrap", 8'hFF, 3'd0, 1'b1);
        apply("lowc0", 8'hFE, 3'd0, 1'b0);
        last_i = 3'd3;
        apply("c0b", 8'hFE, 3'd0, 1'b0);
        apply("c0gap", 8'hFF, 3'd0, 1'b0);
        apply("c1a", 8'hFD, 3'd1, 1'b0);
        apply("c1b", 8'hFD, 3'd1, 1'b0);
        apply("c1gap", 8'hFF, 3'd0, 1'b0);
        apply("c2a", 8'hFB, 3'd2, 1'b0);
        mode_i = 1'b0; select_i = 3'd6;
        apply("todir", 8'hFF, 3'd0, 1'b0);
        apply("dir6", 8'hBF, 3'd6, 1'b0);
        select_i = 3'd1;
        apply("gap61", 8'hFF, 3'd0, 1'b0);
        rst_i = 1'b1;
        apply("rstgap", 8'hFF, 3'd0, 1'b0);
        rst_i = 1'b0;
        apply("post", 8'hFD, 3'd1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
